comm_transmitter: RTL and testbench
===================================

// Module: comm_transmitter
// PURPOSE
//  Serialises one 24-bit game message (ball/miss/new-game fields) onto the single-wire NEO_OUT link.
//  Sits directly upstream of CommunicationReceiver on the opponent board and is its exact encoding mirror.
//  Bits go out MSB first; each bit is a high pulse whose length encodes the value, then a low filler.
//  A low inter-message gap follows every message so the far side can finish and ack.
// PARAMETERS
//  BIT_CYCLES  64   clocks per bit cell (high + low)
//  ONE_HIGH    40   high clocks for a '1' (must be > 26)
//  ZERO_HIGH   12   high clocks for a '0' (must be < 26, >= 1)
//  GAP_CYCLES  128  low clocks after bit 24 before the next message may start
//  CNT_W       8    width of the cycle counter; must hold max(BIT_CYCLES, GAP_CYCLES)
// PORTS
//  clock              in   1  system clock
//  reset              in   1  synchronous, active-low reset (0 = reset)
//  send_request       in   1  request to send the fields below
//  tx_ready           out  1  block can accept a request this cycle
//  message_sent       out  1  one-cycle pulse: message and gap complete
//  ball_y_tx          in   9  ball y position
//  velocity_x_tx      in   4  x velocity magnitude
//  velocity_y_tx      in   4  y velocity magnitude
//  sign_y_tx          in   1  sign of y velocity
//  ball_message_tx    in   1  message carries the ball
//  are_you_there_tx   in   1  presence query
//  I_am_here_tx       in   1  presence reply
//  miss_message_tx    in   1  ball was missed
//  I_lost_tx          in   1  sender lost the game
//  new_game_message_tx in  1  new-game request
//  NEO_OUT            out  1  serial line, registered, idle low
// BEHAVIOUR
//  Packing: frame = {ball_y, vel_x, vel_y, sign_y, ball_msg, are_you_there, I_am_here, miss, I_lost, new_game};
//   frame[23] is sent first.
//  Reset (reset==0 at a clock edge): state IDLE, NEO_OUT=0, message_sent=0, counters and frame register 0.
//   tx_ready=1 in the first cycle after reset.
//  Reset mid-message: line drops low on that edge and the partial frame is abandoned; no message_sent.
//  FSM states: IDLE, HIGH, LOW, GAP.
//   IDLE: tx_ready=1. On send_request=1, capture the packed frame, clear bit_cnt and cyc_cnt, go to HIGH.
//    NEO_OUT goes 1 at the next edge, so the line rises one cycle after acceptance.
//   HIGH: NEO_OUT=1; hold for ONE_HIGH or ZERO_HIGH clocks depending on the current bit, then go to LOW.
//   LOW: NEO_OUT=0 for (BIT_CYCLES - high time) clocks.
//    At the end, bit_cnt+1; if bit_cnt==23 go to GAP, else shift the frame left and go to HIGH.
//   GAP: NEO_OUT=0 for GAP_CYCLES clocks.
//    In the final gap cycle, message_sent=1 for one cycle; the next state is IDLE.
//  Timing: whole message = 24*BIT_CYCLES + GAP_CYCLES = 1664 clocks from the first rising edge of NEO_OUT
//   to the message_sent cycle (inclusive).
//  Field inputs are sampled only in the acceptance cycle and may change freely afterwards.
//  send_request while not tx_ready is ignored (no queueing) unless COMM_TX_QUEUE_EN is defined.
//  Counter widths: bit_cnt is 5 bits; cyc_cnt is CNT_W bits and never wraps (cleared at every state change).
//  Elaboration asserts: ZERO_HIGH < 26 < ONE_HIGH < BIT_CYCLES.
// CONFIGURATION
//  COMM_TX_QUEUE_EN defined:
//   A one-entry holding buffer accepts a request while busy; tx_ready = !buffer_full.
//   In the message_sent cycle, a full buffer moves into the frame register and the FSM goes to HIGH,
//    not IDLE.
//   A request in the same cycle the buffer drains is accepted into the buffer.
//  COMM_TX_QUEUE_EN undefined:
//   No buffer; tx_ready = (state==IDLE); requests while busy are dropped.
// TESTING
//  1. Reset low 3 clocks, release -> NEO_OUT=0, tx_ready=1, message_sent=0.
//  2. Frame 24'h800001 -> bit 23 high 40 clocks; bits 22..1 high 12 each; bit 0 high 40;
//     message_sent 1664 clocks after the first rise.
//  3. Loop NEO_OUT into CommunicationReceiver with ball_y=9'h155, vx=4'hA, vy=4'h3, sign_y=1, ball_msg=1
//     -> receiver fields match exactly; new_message_received asserts.
//  4. Hold send_request=1 across two messages (queue off) -> second frame starts exactly 1 clock after
//     message_sent; no request accepted while busy.
//  5. Assert reset at bit 10 -> NEO_OUT=0 next edge; no message_sent; the next request transmits a full
//     clean frame.
//  6. With COMM_TX_QUEUE_EN: request A, then B at bit 5 -> B starts right after A's gap with no IDLE cycle;
//     tx_ready=0 until the buffer drains.

Source files
------------

// File: rtl/comm_transmitter_if.sv
// Request/field bus between a game-logic producer and comm_transmitter.
// The master drives the message fields and send_request; the slave reports readiness and completion.
interface comm_transmitter_if;
  logic       send_request;
  logic       tx_ready;
  logic       message_sent;
  logic [8:0] ball_y_tx;
  logic [3:0] velocity_x_tx;
  logic [3:0] velocity_y_tx;
  logic       sign_y_tx;
  logic       ball_message_tx;
  logic       are_you_there_tx;
  logic       I_am_here_tx;
  logic       miss_message_tx;
  logic       I_lost_tx;
  logic       new_game_message_tx;

  modport master (
    output send_request, ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
           ball_message_tx, are_you_there_tx, I_am_here_tx, miss_message_tx,
           I_lost_tx, new_game_message_tx,
    input  tx_ready, message_sent
  );

  modport slave (
    input  send_request, ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
           ball_message_tx, are_you_there_tx, I_am_here_tx, miss_message_tx,
           I_lost_tx, new_game_message_tx,
    output tx_ready, message_sent
  );
endinterface

// File: rtl/comm_transmitter.sv
// Serialises a 24-bit game message MSB first onto NEO_OUT as pulse-width coded bits plus a trailing gap.
// Optional macro COMM_TX_QUEUE_EN adds a one-entry holding buffer so a request can be taken while busy.
module comm_transmitter #(
  parameter int BIT_CYCLES = 64,
  parameter int ONE_HIGH   = 40,
  parameter int ZERO_HIGH  = 12,
  parameter int GAP_CYCLES = 128,
  parameter int CNT_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  comm_transmitter_if.slave   bus,
  output logic                NEO_OUT
);

  if (!(ZERO_HIGH >= 1 && ZERO_HIGH < 26 && ONE_HIGH > 26 && ONE_HIGH < BIT_CYCLES)) begin : g_bad_timing
    $error("comm_transmitter: need 1 <= ZERO_HIGH < 26 < ONE_HIGH < BIT_CYCLES");
  end
  if (GAP_CYCLES < 2 || BIT_CYCLES > (1 << CNT_W) || GAP_CYCLES > (1 << CNT_W)) begin : g_bad_cnt
    $error("comm_transmitter: GAP_CYCLES >= 2 and CNT_W must cover BIT_CYCLES and GAP_CYCLES");
  end

  localparam logic [CNT_W-1:0] ONE_HI_END  = CNT_W'(ONE_HIGH - 1);
  localparam logic [CNT_W-1:0] ZERO_HI_END = CNT_W'(ZERO_HIGH - 1);
  localparam logic [CNT_W-1:0] ONE_LO_END  = CNT_W'(BIT_CYCLES - ONE_HIGH - 1);
  localparam logic [CNT_W-1:0] ZERO_LO_END = CNT_W'(BIT_CYCLES - ZERO_HIGH - 1);
  localparam logic [CNT_W-1:0] GAP_END     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_PRE     = CNT_W'(GAP_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t           state;
  logic [23:0]      frame;
  logic [4:0]       bit_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             sent_q;
  logic [23:0]      req_frame;
  logic             gap_end;

  assign req_frame = {bus.ball_y_tx, bus.velocity_x_tx, bus.velocity_y_tx, bus.sign_y_tx,
                      bus.ball_message_tx, bus.are_you_there_tx, bus.I_am_here_tx,
                      bus.miss_message_tx, bus.I_lost_tx, bus.new_game_message_tx};
  assign gap_end = (state == GAP) && (cyc_cnt == GAP_END);
  assign bus.message_sent = sent_q;

`ifdef COMM_TX_QUEUE_EN
  logic        buf_full;
  logic [23:0] buf_frame;
  logic        drain;
  logic        take;
  // A request arriving as the buffer empties refills it straight away.
  assign drain = gap_end && buf_full;
  assign take  = bus.send_request && (state != IDLE) && (!buf_full || drain);
  assign bus.tx_ready = !buf_full;
`else
  assign bus.tx_ready = (state == IDLE);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      frame   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      sent_q  <= 1'b0;
      NEO_OUT <= 1'b0;
`ifdef COMM_TX_QUEUE_EN
      buf_full  <= 1'b0;
      buf_frame <= '0;
`endif
    end else begin
`ifdef COMM_TX_QUEUE_EN
      if (take) begin
        buf_frame <= req_frame;
        buf_full  <= 1'b1;
      end else if (drain) begin
        buf_full  <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.send_request) begin
            frame   <= req_frame;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            NEO_OUT <= 1'b1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (cyc_cnt == (frame[23] ? ONE_HI_END : ZERO_HI_END)) begin
            cyc_cnt <= '0;
            NEO_OUT <= 1'b0;
            state   <= LOW;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        LOW: begin
          if (cyc_cnt == (frame[23] ? ONE_LO_END : ZERO_LO_END)) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 5'd23) begin
              state <= GAP;
            end else begin
              frame   <= {frame[22:0], 1'b0};
              NEO_OUT <= 1'b1;
              state   <= HIGH;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_end) begin
            cyc_cnt <= '0;
            sent_q  <= 1'b0;
            state   <= IDLE;
`ifdef COMM_TX_QUEUE_EN
            // Back-to-back: buffered frame starts with no idle cycle.
            if (buf_full) begin
              frame   <= buf_frame;
              bit_cnt <= '0;
              NEO_OUT <= 1'b1;
              state   <= HIGH;
            end
`endif
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            // Registered so the pulse lands exactly on the final gap cycle.
            if (cyc_cnt == GAP_PRE) sent_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_transmitter.sv
// Directed-plus-random bench for comm_transmitter: line waveform is predicted from bit-cell arithmetic
// and decoded back by pulse width.
module tb_comm_transmitter;
  localparam int BIT  = 64;
  localparam int ONE  = 40;
  localparam int ZERO = 12;
  localparam int GAP  = 128;
  localparam int MSG  = 24 * BIT + GAP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic neo;
  int   checks = 0;
  int   errors = 0;

  comm_transmitter_if bus();

  comm_transmitter dut (
    .clock   (clk),
    .reset   (rst_n),
    .bus     (bus),
    .NEO_OUT (neo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [23:0] f);
    bus.ball_y_tx           = f[23:15];
    bus.velocity_x_tx       = f[14:11];
    bus.velocity_y_tx       = f[10:7];
    bus.sign_y_tx           = f[6];
    bus.ball_message_tx     = f[5];
    bus.are_you_there_tx    = f[4];
    bus.I_am_here_tx        = f[3];
    bus.miss_message_tx     = f[2];
    bus.I_lost_tx           = f[1];
    bus.new_game_message_tx = f[0];
  endtask

  // Expected line level k cycles after the acceptance edge.
  function automatic logic model_line(input logic [23:0] f, input int k);
    int b;
    if (k >= 24 * BIT) return 1'b0;
    b = k / BIT;
    return (k % BIT) < (f[23-b] ? ONE : ZERO);
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic request(input logic [23:0] f, input bit hold);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_request", 32'(bus.tx_ready), 1);
    set_fields(f);
    bus.send_request = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.send_request = 1'b0;
      set_fields(24'($urandom));
    end
  endtask

  task automatic capture(input string tag, input logic [23:0] f, input bit scramble);
    logic [23:0] dec = '0;
    int run = 0;
    int sent_at = -1;
    int first_bad = -1;
    for (int k = 0; k < MSG; k++) begin
      @(negedge clk);
      if (neo !== model_line(f, k) || bus.message_sent !== (k == MSG - 1) || bus.tx_ready !== 1'b0)
        if (first_bad < 0) first_bad = k;
      if (neo === 1'b1) run++;
      else begin
        if (run > 0) dec = {dec[22:0], run > 26};
        run = 0;
      end
      if (bus.message_sent === 1'b1 && sent_at < 0) sent_at = k;
      if (scramble && k < MSG - 1) set_fields(24'($urandom));
    end
    check({tag, "_frame"}, 32'(dec), 32'(f));
    check({tag, "_sent_at"}, sent_at, MSG - 1);
    check({tag, "_first_bad_cycle"}, first_bad, -1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_line"}, 32'(neo), 0);
    check({tag, "_idle_ready"}, 32'(bus.tx_ready), 1);
    check({tag, "_idle_sent"}, 32'(bus.message_sent), 0);
  endtask

  initial begin
    logic [23:0] f;
    logic [23:0] f2;
    int stray;

    bus.send_request = 1'b0;
    set_fields('0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_line", 32'(neo), 0);
    check("reset_ready", 32'(bus.tx_ready), 1);
    check("reset_sent", 32'(bus.message_sent), 0);

    // MSB and LSB set, everything between zero.
    request(24'h800001, 0);
    capture("t2", 24'h800001, 0);
    check_idle("t2");

    // Ball message with recognisable field values.
    f = {9'h155, 4'hA, 4'h3, 1'b1, 1'b1, 5'b00000};
    request(f, 0);
    capture("t3", f, 0);
    check_idle("t3");

    repeat (3) begin
      f = 24'($urandom);
      request(f, 0);
      capture("rand", f, 0);
      check_idle("rand");
    end

    // Request held high; busy-time field changes must not leak into either frame.
    f  = 24'($urandom);
    f2 = 24'($urandom);
    request(f, 1);
    capture("t4a", f, 1);
    set_fields(f2);
    @(negedge clk);
    check("t4_gap_idle_ready", 32'(bus.tx_ready), 1);
    check("t4_gap_idle_line", 32'(neo), 0);
    @(posedge clk);
    #1;
    bus.send_request = 1'b0;
    set_fields(24'($urandom));
    capture("t4b", f2, 0);
    check_idle("t4b");

    // Reset in the middle of bit 10.
    f = 24'($urandom);
    request(f, 0);
    repeat (10 * BIT + 5) @(negedge clk);
    check("t5_line_before_reset", 32'(neo), 32'(model_line(f, 10 * BIT + 4)));
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_reset_line", 32'(neo), 0);
    check("t5_reset_ready", 32'(bus.tx_ready), 1);
    check("t5_reset_sent", 32'(bus.message_sent), 0);
    rst_n = 1'b1;
    stray = 0;
    repeat (2 * MSG) begin
      @(negedge clk);
      if (bus.message_sent !== 1'b0 || neo !== 1'b0) stray++;
    end
    check("t5_no_activity_after_abort", stray, 0);
    f = 24'($urandom);
    request(f, 0);
    capture("t5_clean", f, 0);
    check_idle("t5_clean");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
